digi_clock_core: RTL and testbench
==================================

// Module: digi_clock_core
// PURPOSE
//  Parametrised time-of-day engine for the seven-segment display clock. Has an internal
//  prescaler, a BCD hh:mm:ss chain, 12/24 h display mode, validated load and an alarm FSM.
//  Fed directly by the board clock. Its six BCD digits drive six seg7_lut instances in the top level.
// PARAMETERS
//  CLK_HZ    50000000  input clock frequency
//  TICK_HZ   1         time-step rate; DIV = CLK_HZ/TICK_HZ (>=2, integer)
//  PRE_W     26        prescaler width; must satisfy 2**PRE_W >= DIV
//  RING_SEC  30        seconds the alarm rings before auto-stop (1..59)
//  SNOOZE_MIN 5        snooze length in minutes (1..59)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  en         in   1   run enable; 0 freezes prescaler and time
//  clr        in   1   sync clear: time=00:00:00, prescaler=0
//  load       in   1   sync load of ld_time (24 h BCD)
//  ld_time    in   24  {h1,h0,m1,m0,s1,s0}, 4 bit BCD each
//  mode_12h   in   1   1: 12 h display; 0: 24 h display
//  al_wr      in   1   latch al_time into alarm register
//  al_time    in   16  {h1,h0,m1,m0} alarm, 24 h BCD
//  al_en      in   1   alarm arm
//  al_stop    in   1   stop ringing or cancel snooze -> IDLE
//  al_snooze  in   1   snooze request (DCLK_SNOOZE_EN only)
//  time_bcd   out  24  displayed {h1,h0,m1,m0,s1,s0}
//  pm         out  1   1 when internal hour >= 12 (both modes)
//  tick       out  1   1-cycle pulse per time step
//  ring       out  1   alarm sounding
//  load_err   out  1   1-cycle pulse: load rejected
// BEHAVIOUR
//  Reset: time 00:00:00, prescaler 0, alarm reg 00:00, FSM IDLE; tick=ring=load_err=0.
//  Time is stored internally in 24 h. Prescaler counts 0..DIV-1 while en=1.
//  tick is asserted in the cycle where count==DIV-1; that same edge advances the seconds.
//  Carry chain: s 59->00 carries to m; m 59->00 carries to h; h 23->00 wraps. All carries resolve in one cycle.
//  Priority per cycle: clr > load > tick. clr/load act regardless of en and zero the prescaler.
//  Load validity: each digit <=9, s1/m1 <=5, hours <=23. An invalid load leaves time unchanged
//   and pulses load_err in the next cycle.
//  Display: 24 h output is the internal value. 12 h output maps h=0 -> 12, h=13..23 -> h-12; pm is unchanged.
//  Output is registered: time_bcd updates 1 cycle after the changing edge.
//  Alarm FSM: IDLE, RING, SNOOZE.
//   IDLE->RING: al_en=1 and a tick makes time == alarm:00.
//   RING->IDLE: al_stop, al_en=0, or RING_SEC ticks elapsed.
//   RING->SNOOZE: al_snooze (macro only). SNOOZE->RING after SNOOZE_MIN*60 ticks.
//   SNOOZE->IDLE: al_stop or al_en=0.
//  ring=1 only in RING. al_stop takes priority over al_snooze.
//  al_wr in RING/SNOOZE updates the register only; the current session continues.
//  clr/load during RING or SNOOZE: FSM -> IDLE. A load that itself equals the alarm does not trigger.
//  Asserting rst_n low mid-operation returns everything to its reset values immediately.
// CONFIGURATION
//  DCLK_SNOOZE_EN defined: SNOOZE state and its minute counter are built.
//  Undefined: al_snooze is ignored, SNOOZE is unreachable, and its counter is removed.
// STRUCTURE
//  Package digi_clock_pkg holds:
//   - alarm state enum typedef {IDLE,RING,SNOOZE}
//   - BCD digit typedef
//   - constants for the 59/23 wrap limits
//  Sub-module bcd_mod_cnt (parametric modulo BCD two-digit counter with inc, carry, load, clr):
//   three instances for s, m, h. The 12 h conversion and the FSM stay in the top level.
// TESTING (CLK_HZ=4, TICK_HZ=1 -> DIV=4)
//  1. Reset, en=1 for 12 clk -> tick pulses 3 times (cycles 4,8,12); time_bcd=00:00:03.
//  2. Load 23:59:59, one tick -> 00:00:00; load 12:59:59, tick -> 13:00:00, pm=1;
//     with mode_12h=1 time_bcd=01:00:00.
//  3. Load 24:00:00 or 12:60:00 -> load_err one cycle, time unchanged. clr and load together -> 00:00:00.
//  4. al_time=07:00, al_en=1, load 06:59:59, tick -> ring=1. After RING_SEC ticks -> ring=0.
//     Repeat the run with al_stop mid-ring -> ring=0 the next cycle.
//  5. DCLK_SNOOZE_EN: al_snooze in RING -> ring=0; after SNOOZE_MIN*60 ticks -> ring=1.
//     Without the macro, al_snooze has no effect.
//  6. Assert rst_n low during RING -> ring=0 and time 00:00:00 asynchronously.

Source files
------------

// File: rtl/digi_clock_pkg.sv
// Shared types, wrap limits and BCD helpers for the time-of-day engine.
package digi_clock_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   localparam logic [7:0] SEC_MAX  = 8'h59;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] HOUR_MAX = 8'h23;

   function automatic logic time_valid(input logic [23:0] t);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ok = ok & (t[i*4 +: 4] <= 4'd9);
      end
      // BCD compares are ordinal once every digit is <= 9
      ok = ok & (t[15:12] <= 4'd5) & (t[7:4] <= 4'd5) & (t[23:16] <= HOUR_MAX);
      return ok;
   endfunction

   function automatic logic [7:0] hour_to_12h(input logic [7:0] h);
      logic [4:0] bin;
      logic [4:0] adj;
      logic [7:0] r;
      adj = 5'd0;
      bin = ({1'b0, h[7:4]} * 5'd10) + {1'b0, h[3:0]};
      if (bin == 5'd0) begin
         r = 8'h12;
      end else if (bin > 5'd12) begin
         adj = bin - 5'd12;
         r   = (adj >= 5'd10) ? {4'd1, 4'(adj - 5'd10)} : {4'd0, adj[3:0]};
      end else begin
         r = h;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD counter wrapping at MAX_BCD, with clear, load and carry-out.
module bcd_mod_cnt
   import digi_clock_pkg::*;
#(
   parameter logic [7:0] MAX_BCD = 8'h59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       load,
   input  logic       inc,
   input  logic [7:0] ld_val,
   output logic [7:0] q,
   output logic [7:0] nxt,
   output logic       carry
);

   logic [7:0] q_r;
   logic [7:0] nxt_s;
   logic [7:0] inc_val_s;
   bcd_t       hi_s;
   bcd_t       lo_s;

   // BCD increment with wrap at the modulus
   always_comb begin
      hi_s = q_r[7:4];
      lo_s = q_r[3:0];
      if (q_r == MAX_BCD) begin
         inc_val_s = 8'h00;
      end else if (lo_s == 4'd9) begin
         inc_val_s = {hi_s + 4'd1, 4'd0};
      end else begin
         inc_val_s = {hi_s, lo_s + 4'd1};
      end
   end

   // next value, clear over load over increment
   always_comb begin
      if (clr) begin
         nxt_s = 8'h00;
      end else if (load) begin
         nxt_s = ld_val;
      end else if (inc) begin
         nxt_s = inc_val_s;
      end else begin
         nxt_s = q_r;
      end
   end

   // digit register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= 8'h00;
      end else begin
         q_r <= nxt_s;
      end
   end

   assign q     = q_r;
   assign nxt   = nxt_s;
   assign carry = inc & (q_r == MAX_BCD);

endmodule

// File: rtl/digi_clock_core.sv
// Time-of-day engine: prescaler, BCD hh:mm:ss chain, 12/24 h display, validated load, alarm FSM.
// Define DCLK_SNOOZE_EN to build the SNOOZE state and its minute counter.
module digi_clock_core
   import digi_clock_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TICK_HZ    = 1,
   parameter int PRE_W      = 26,
   parameter int RING_SEC   = 30,
   parameter int SNOOZE_MIN = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        clr,
   input  logic        load,
   input  logic [23:0] ld_time,
   input  logic        mode_12h,
   input  logic        al_wr,
   input  logic [15:0] al_time,
   input  logic        al_en,
   input  logic        al_stop,
   input  logic        al_snooze,
   output logic [23:0] time_bcd,
   output logic        pm,
   output logic        tick,
   output logic        ring,
   output logic        load_err
);

   localparam int               DIV       = CLK_HZ / TICK_HZ;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
   localparam logic [PRE_W-1:0] PRE_ZERO  = PRE_W'(0);
   localparam logic [5:0]       RING_LAST = 6'(RING_SEC - 1);

   logic [PRE_W-1:0] pre_r;
   logic             tick_s;
   logic             adv_s;
   logic             ld_ok_s;
   logic             do_load_s;
   logic [7:0]       s_q_s, m_q_s, h_q_s;
   logic [7:0]       s_nxt_s, m_nxt_s, h_nxt_s;
   logic             s_carry_s, m_carry_s, unused_h_carry_s;
   logic [15:0]      al_reg_r;
   alarm_state_t     state_r, state_nxt_s;
   logic [5:0]       ring_cnt_r;
   logic             ring_done_s;
   logic             alarm_hit_s;
   logic             ring_s;
   logic [23:0]      time_r;
   logic             pm_r;
   logic             load_err_r;

   assign tick_s    = en & (pre_r == PRE_LAST);
   // clr and any load pre-empt the time step on the same edge
   assign adv_s     = tick_s & ~clr & ~load;
   assign ld_ok_s   = time_valid(ld_time);
   assign do_load_s = load & ~clr & ld_ok_s;

   // prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_r <= PRE_ZERO;
      end else if (clr | load) begin
         pre_r <= PRE_ZERO;
      end else if (en) begin
         pre_r <= tick_s ? PRE_ZERO : pre_r + PRE_ONE;
      end else begin
         pre_r <= pre_r;
      end
   end

   bcd_mod_cnt #(.MAX_BCD(SEC_MAX)) u_sec (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(do_load_s), .inc(adv_s),
      .ld_val(ld_time[7:0]), .q(s_q_s), .nxt(s_nxt_s), .carry(s_carry_s)
   );

   bcd_mod_cnt #(.MAX_BCD(MIN_MAX)) u_min (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(do_load_s), .inc(s_carry_s),
      .ld_val(ld_time[15:8]), .q(m_q_s), .nxt(m_nxt_s), .carry(m_carry_s)
   );

   bcd_mod_cnt #(.MAX_BCD(HOUR_MAX)) u_hour (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(do_load_s), .inc(m_carry_s),
      .ld_val(ld_time[23:16]), .q(h_q_s), .nxt(h_nxt_s), .carry(unused_h_carry_s)
   );

   // registered display, pm flag and load rejection pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_r     <= 24'h000000;
         pm_r       <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         time_r     <= {(mode_12h ? hour_to_12h(h_q_s) : h_q_s), m_q_s, s_q_s};
         pm_r       <= (h_q_s >= 8'h12);
         load_err_r <= load & ~clr & ~ld_ok_s;
      end
   end

   // alarm time register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         al_reg_r <= 16'h0000;
      end else if (al_wr) begin
         al_reg_r <= al_time;
      end else begin
         al_reg_r <= al_reg_r;
      end
   end

   // compare against the post-step time so the ringing starts on the matching tick
   assign alarm_hit_s = al_en & adv_s & ({h_nxt_s, m_nxt_s, s_nxt_s} == {al_reg_r, 8'h00});
   assign ring_done_s = adv_s & (ring_cnt_r == RING_LAST);

   // ticks spent ringing in the current session
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ring_cnt_r <= 6'd0;
      end else if (state_r != RING) begin
         ring_cnt_r <= 6'd0;
      end else if (adv_s) begin
         ring_cnt_r <= ring_cnt_r + 6'd1;
      end else begin
         ring_cnt_r <= ring_cnt_r;
      end
   end

`ifdef DCLK_SNOOZE_EN
   localparam logic [11:0] SNZ_LAST = 12'((SNOOZE_MIN * 60) - 1);

   logic [11:0] snz_cnt_r;
   logic        snz_done_s;

   // ticks spent snoozing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snz_cnt_r <= 12'd0;
      end else if (state_r != SNOOZE) begin
         snz_cnt_r <= 12'd0;
      end else if (adv_s) begin
         snz_cnt_r <= snz_cnt_r + 12'd1;
      end else begin
         snz_cnt_r <= snz_cnt_r;
      end
   end

   assign snz_done_s = adv_s & (snz_cnt_r == SNZ_LAST);
`else
   localparam int unused_snooze_min = SNOOZE_MIN;
   logic unused_snooze_s;
   assign unused_snooze_s = al_snooze;
`endif

   // alarm state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // alarm next-state
   always_comb begin
      state_nxt_s = state_r;
      if (clr | load) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (alarm_hit_s) state_nxt_s = RING;
               else             state_nxt_s = IDLE;
            end
            RING: begin
               if (al_stop | ~al_en)  state_nxt_s = IDLE;
`ifdef DCLK_SNOOZE_EN
               else if (al_snooze)    state_nxt_s = SNOOZE;
`endif
               else if (ring_done_s)  state_nxt_s = IDLE;
               else                   state_nxt_s = RING;
            end
            SNOOZE: begin
`ifdef DCLK_SNOOZE_EN
               if (al_stop | ~al_en)  state_nxt_s = IDLE;
               else if (snz_done_s)   state_nxt_s = RING;
               else                   state_nxt_s = SNOOZE;
`else
               state_nxt_s = IDLE;
`endif
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // alarm outputs
   always_comb begin
      ring_s = (state_r == RING);
   end

   assign time_bcd = time_r;
   assign pm       = pm_r;
   assign tick     = tick_s;
   assign ring     = ring_s;
   assign load_err = load_err_r;

endmodule

// File: tb/tb_digi_clock_core.sv
// Self-checking bench for digi_clock_core with DIV=4; reference model works in seconds-of-day.
module tb_digi_clock_core;

   localparam int DIV        = 4;
   localparam int RING_SEC   = 30;
   localparam int SNOOZE_MIN = 5;
   localparam int DAY        = 86400;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, clr, load, mode_12h, al_wr, al_en, al_stop, al_snooze;
   logic [23:0] ld_time;
   logic [15:0] al_time;
   logic [23:0] time_bcd;
   logic        pm, tick, ring, load_err;

   digi_clock_core #(
      .CLK_HZ(4), .TICK_HZ(1), .PRE_W(3), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .ld_time(ld_time),
      .mode_12h(mode_12h), .al_wr(al_wr), .al_time(al_time), .al_en(al_en),
      .al_stop(al_stop), .al_snooze(al_snooze), .time_bcd(time_bcd), .pm(pm),
      .tick(tick), .ring(ring), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int tick_seen = 0;

   // reference state: time as seconds of day, alarm as minute of day
   int          m_secs, m_pre, m_al_min, m_st, m_rt, m_sn;
   logic [23:0] m_disp;
   logic        m_pm, m_err;

   task automatic check_val(input string tag, input logic [23:0] act, input logic [23:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] fmt(input int secs, input logic m12);
      int h, m, s;
      h = secs / 3600;
      m = (secs / 60) % 60;
      s = secs % 60;
      if (m12) begin
         if (h == 0)      h = 12;
         else if (h > 12) h = h - 12;
      end
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_pre = 0; m_al_min = 0; m_st = 0; m_rt = 0; m_sn = 0;
      m_disp = 24'h000000; m_pm = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step();
      int hh, mm, ss, nsecs;
      bit valid, tk, adv;
      hh = int'(ld_time[23:20]) * 10 + int'(ld_time[19:16]);
      mm = int'(ld_time[15:12]) * 10 + int'(ld_time[11:8]);
      ss = int'(ld_time[7:4]) * 10 + int'(ld_time[3:0]);
      valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (((ld_time >> (i * 4)) & 24'hF) > 24'd9) valid = 1'b0;
      end
      if (hh >= 24 || mm >= 60 || ss >= 60) valid = 1'b0;
      tk  = en && (m_pre == DIV - 1);
      adv = tk && !clr && !load;
      m_disp = fmt(m_secs, mode_12h);
      m_pm   = (m_secs >= 12 * 3600);
      m_err  = load && !clr && !valid;
      if (clr)                nsecs = 0;
      else if (load && valid) nsecs = hh * 3600 + mm * 60 + ss;
      else if (adv)           nsecs = (m_secs + 1) % DAY;
      else                    nsecs = m_secs;
      if (clr || load) begin
         m_st = 0;
      end else begin
         case (m_st)
            0: if (al_en && adv && nsecs == m_al_min * 60) begin m_st = 1; m_rt = 0; end
            1: begin
               if (al_stop || !al_en) m_st = 0;
`ifdef DCLK_SNOOZE_EN
               else if (al_snooze) begin m_st = 2; m_sn = 0; end
`endif
               else if (adv) begin
                  m_rt++;
                  if (m_rt == RING_SEC) m_st = 0;
               end
            end
            2: begin
               if (al_stop || !al_en) m_st = 0;
               else if (adv) begin
                  m_sn++;
                  if (m_sn == SNOOZE_MIN * 60) begin m_st = 1; m_rt = 0; end
               end
            end
            default: m_st = 0;
         endcase
      end
      m_secs = nsecs;
      if (clr || load) m_pre = 0;
      else if (en)     m_pre = (m_pre + 1) % DIV;
      if (al_wr) m_al_min = (int'(al_time[15:12]) * 10 + int'(al_time[11:8])) * 60
                          + int'(al_time[7:4]) * 10 + int'(al_time[3:0]);
   endtask

   // compare all outputs against the model, then advance one clock
   task automatic cycle();
      #1;
      if (tick === 1'b1) tick_seen++;
      check_val("tick", {23'd0, tick}, {23'd0, (en && m_pre == DIV - 1)});
      check_val("ring", {23'd0, ring}, {23'd0, (m_st == 1)});
      check_val("time_bcd", time_bcd, m_disp);
      check_val("pm", {23'd0, pm}, {23'd0, m_pm});
      check_val("load_err", {23'd0, load_err}, {23'd0, m_err});
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      en = 1'b0; clr = 1'b0; load = 1'b0; ld_time = 24'h000000; mode_12h = 1'b0;
      al_wr = 1'b0; al_time = 16'h0000; al_en = 1'b0; al_stop = 1'b0; al_snooze = 1'b0;
   endtask

   task automatic load_time(input logic [23:0] t);
      load = 1'b1; ld_time = t;
      cycle();
      load = 1'b0;
   endtask

   initial begin
      int t;
      idle_inputs();
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_val("rst_time", time_bcd, 24'h000000);
      check_val("rst_tick", {23'd0, tick}, 24'd0);
      check_val("rst_ring", {23'd0, ring}, 24'd0);
      check_val("rst_err", {23'd0, load_err}, 24'd0);
      check_val("rst_pm", {23'd0, pm}, 24'd0);
      rst_n = 1'b1;

      // 1: free run, ticks on cycles 4, 8, 12
      en = 1'b1;
      repeat (12) cycle();
      check_val("t1_ticks", 24'(tick_seen), 24'd3);
      en = 1'b0;
      cycle();
      check_val("t1_time", time_bcd, 24'h000003);

      // 2: wrap and 12 h display
      en = 1'b1;
      load_time(24'h235959);
      repeat (5) cycle();
      check_val("t2_wrap", time_bcd, 24'h000000);
      load_time(24'h125959);
      repeat (5) cycle();
      check_val("t2_13h", time_bcd, 24'h130000);
      check_val("t2_pm", {23'd0, pm}, 24'd1);
      mode_12h = 1'b1;
      cycle();
      check_val("t2_12h", time_bcd, 24'h010000);
      check_val("t2_pm12", {23'd0, pm}, 24'd1);
      mode_12h = 1'b0;

      // 3: rejected loads, clr beats load
      en = 1'b0;
      cycle();
      load_time(24'h240000);
      check_val("t3_err24", {23'd0, load_err}, 24'd1);
      cycle();
      check_val("t3_err_pulse", {23'd0, load_err}, 24'd0);
      check_val("t3_hold24", time_bcd, 24'h130000);
      load_time(24'h126000);
      check_val("t3_err60", {23'd0, load_err}, 24'd1);
      cycle();
      check_val("t3_hold60", time_bcd, 24'h130000);
      clr = 1'b1;
      load_time(24'h050000);
      clr = 1'b0;
      cycle();
      check_val("t3_clr_load", time_bcd, 24'h000000);

      // 4: alarm fires, auto-stops, then manual stop
      en = 1'b1;
      al_time = 16'h0700; al_wr = 1'b1;
      cycle();
      al_wr = 1'b0; al_en = 1'b1;
      load_time(24'h065959);
      repeat (3) cycle();
      check_val("t4_pre_ring", {23'd0, ring}, 24'd0);
      cycle();
      check_val("t4_ring_on", {23'd0, ring}, 24'd1);
      repeat (RING_SEC * DIV - 1) cycle();
      check_val("t4_ring_last", {23'd0, ring}, 24'd1);
      cycle();
      check_val("t4_auto_stop", {23'd0, ring}, 24'd0);
      load_time(24'h065959);
      repeat (4) cycle();
      check_val("t4_ring2", {23'd0, ring}, 24'd1);
      repeat (10) cycle();
      al_stop = 1'b1;
      cycle();
      al_stop = 1'b0;
      check_val("t4_stop", {23'd0, ring}, 24'd0);

      // 5: snooze
      load_time(24'h065959);
      repeat (4) cycle();
      check_val("t5_ring", {23'd0, ring}, 24'd1);
      al_snooze = 1'b1;
      cycle();
      al_snooze = 1'b0;
`ifdef DCLK_SNOOZE_EN
      check_val("t5_snoozed", {23'd0, ring}, 24'd0);
      repeat (SNOOZE_MIN * 60 * DIV - 2) cycle();
      check_val("t5_still_snooze", {23'd0, ring}, 24'd0);
      cycle();
      check_val("t5_rering", {23'd0, ring}, 24'd1);
`else
      check_val("t5_no_snooze", {23'd0, ring}, 24'd1);
`endif
      al_stop = 1'b1;
      cycle();
      al_stop = 1'b0;

      // 6: asynchronous reset while ringing
      load_time(24'h065959);
      repeat (4) cycle();
      check_val("t6_ring", {23'd0, ring}, 24'd1);
      repeat (3) cycle();
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_ring_off", {23'd0, ring}, 24'd0);
      check_val("t6_time", time_bcd, 24'h000000);
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(0, 9) != 0);
         clr       = ($urandom_range(0, 199) == 0);
         load      = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 0) begin
            t = (m_al_min * 60 - int'($urandom_range(1, 3)) + DAY) % DAY;
            ld_time = fmt(t, 1'b0);
         end else begin
            ld_time = 24'($urandom());
         end
         if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
         al_wr = ($urandom_range(0, 99) == 0);
         t = int'($urandom_range(0, DAY - 1)) / 60;
         al_time = {4'((t / 60) / 10), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'((t % 60) % 10)};
         al_en     = ($urandom_range(0, 29) != 0);
         al_stop   = ($urandom_range(0, 99) == 0);
         al_snooze = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
